// File: rtl/vmem_wr_arb.sv
// Video-memory port arbiter: scan-out reads own the port during active display,
// two small write FIFOs drain round-robin into memory during blanking.
`timescale 1ns/1ps
module vmem_wr_arb #(
    parameter int HW    = 10,
    parameter int VW    = 9,
    parameter int DW    = 24,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [HW-1:0]             h_addr,
    input  logic [VW-1:0]             v_addr,
    input  logic                      valid,
    output logic [DW-1:0]             vga_data,
    input  logic                      wr0_valid,
    output logic                      wr0_ready,
    input  logic [HW-1:0]             wr0_h,
    input  logic [VW-1:0]             wr0_v,
    input  logic [DW-1:0]             wr0_data,
    input  logic                      wr1_valid,
    output logic                      wr1_ready,
    input  logic [HW-1:0]             wr1_h,
    input  logic [VW-1:0]             wr1_v,
    input  logic [DW-1:0]             wr1_data,
    output logic [HW+VW-1:0]          mem_addr,
    output logic                      mem_we,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata,
    output logic [$clog2(DEPTH):0]    wr0_cnt,
    output logic [$clog2(DEPTH):0]    wr1_cnt
);
    localparam int AW = HW + VW;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = AW + DW;

    // Handshake: a writer pixel transfers on a rising edge where wrN_valid and
    // wrN_ready are both 1; wrN_ready depends only on registered occupancy.

    logic [EW-1:0] r_fifo [2][DEPTH];
    logic [PW-1:0] r_wp [2];
    logic [PW-1:0] r_rp [2];
    logic [CW-1:0] r_cnt [2];
    logic          r_rr;

    logic [1:0]    w_in_valid;
    logic [1:0]    w_ready;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [1:0]    w_ne;
    logic [EW-1:0] w_in_entry [2];
    logic [EW-1:0] w_head [2];
    logic          w_drain;
    logic          w_grant;

    assign w_in_valid    = {wr1_valid, wr0_valid};
    assign w_in_entry[0] = {wr0_h, wr0_v, wr0_data};
    assign w_in_entry[1] = {wr1_h, wr1_v, wr1_data};

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            w_ne[n]   = (r_cnt[n] != '0);
            w_ready[n] = (r_cnt[n] != CW'(DEPTH));
            w_push[n] = w_in_valid[n] && w_ready[n];
            w_head[n] = r_fifo[n][r_rp[n]];
        end
    end

    // Drain only in blanking; with a single non-empty FIFO it wins outright.
    assign w_drain  = !valid && (|w_ne);
    assign w_grant  = (&w_ne) ? r_rr : w_ne[1];
    assign w_pop[0] = w_drain && !w_grant;
    assign w_pop[1] = w_drain && w_grant;

    assign mem_we    = w_drain;
    assign mem_addr  = w_drain ? w_head[w_grant][EW-1:DW] : {h_addr, v_addr};
    assign mem_wdata = w_drain ? w_head[w_grant][DW-1:0] : w_head[0][DW-1:0];
    assign vga_data  = valid ? mem_rdata : '0;

    assign wr0_ready = w_ready[0];
    assign wr1_ready = w_ready[1];
    assign wr0_cnt   = r_cnt[0];
    assign wr1_cnt   = r_cnt[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                r_wp[n]  <= '0;
                r_rp[n]  <= '0;
                r_cnt[n] <= '0;
            end
            r_rr <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (w_push[n]) r_wp[n] <= r_wp[n] + PW'(1);
                if (w_pop[n])  r_rp[n] <= r_rp[n] + PW'(1);
                if (w_push[n] && !w_pop[n])
                    r_cnt[n] <= r_cnt[n] + CW'(1);
                else if (!w_push[n] && w_pop[n])
                    r_cnt[n] <= r_cnt[n] - CW'(1);
            end
            if (w_drain) r_rr <= ~w_grant;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (w_push[n]) r_fifo[n][r_wp[n]] <= w_in_entry[n];
        end
    end

endmodule
